// File: rtl/spm_driver_if.sv
// Bus bundle between the spm driver, its host and the serial-parallel multiplier core.
interface spm_driver_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_x;
    logic [WIDTH-1:0]       in_y;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_p;
    logic [WIDTH-1:0]       spm_x;
    logic                   spm_y;
    logic                   spm_clr;
    logic                   spm_p;

    // Driver side: accepts operands, returns products, drives the core.
    modport master (
        input  in_valid, in_x, in_y, out_ready, spm_p,
        output in_ready, out_valid, out_p, spm_x, spm_y, spm_clr
    );

    // Environment side: host plus core.
    modport slave (
        output in_valid, in_x, in_y, out_ready, spm_p,
        input  in_ready, out_valid, out_p, spm_x, spm_y, spm_clr
    );
endinterface

// File: rtl/spm_driver.sv
// spm_driver: feeds a serial-parallel multiplier core one product at a time.
// The multiplier is shifted out LSB first and the serial product is collected
// into a 2*WIDTH-bit result returned over a valid/ready handshake.
module spm_driver #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CORE_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    spm_driver_if.master bus
);
    localparam int unsigned NumShift = 2 * WIDTH + CORE_LAT;
    localparam int unsigned CntW     = $clog2(NumShift + 1);

    localparam logic [CntW-1:0] CntLast  = CntW'(NumShift - 1);
    localparam logic [CntW-1:0] CntLat   = CntW'(CORE_LAT);
    localparam logic [CntW-1:0] CntWidth = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [CntW-1:0]    cnt_inc;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_sh_q;
    logic [2*WIDTH-1:0] p_sh_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               spm_y_q;
    logic               spm_clr_q;

    assign cnt_inc = cnt_q + CntOne;

    // Control FSM; every output is a register so nothing depends combinationally on inputs.
    // spm_y is registered, so it is loaded one cycle ahead from y_sh (bit 1 is the
    // bit due next cycle, which is why WIDTH must be at least 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            x_q         <= '0;
            y_sh_q      <= '0;
            p_sh_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            spm_y_q     <= 1'b0;
            spm_clr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        x_q        <= bus.in_x;
                        y_sh_q     <= bus.in_y;
                        p_sh_q     <= '0;
                        in_ready_q <= 1'b0;
                        spm_clr_q  <= 1'b1;
                        state_q    <= StClear;
                    end
                end
                StClear: begin
                    spm_clr_q <= 1'b0;
                    cnt_q     <= '0;
                    spm_y_q   <= y_sh_q[0];
                    state_q   <= StShift;
                end
                StShift: begin
                    y_sh_q <= y_sh_q >> 1;
                    // The first CORE_LAT cycles carry no product bit yet.
                    if (cnt_q >= CntLat) begin
                        p_sh_q <= {bus.spm_p, p_sh_q[2*WIDTH-1:1]};
                    end
                    if (cnt_q == CntLast) begin
                        spm_y_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q   <= cnt_inc;
                        // Past WIDTH bits the multiplier is zero-extended.
                        spm_y_q <= (cnt_inc < CntWidth) ? y_sh_q[1] : 1'b0;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = p_sh_q;
    assign bus.spm_x     = x_q;
    assign bus.spm_y     = spm_y_q;
    assign bus.spm_clr   = spm_clr_q;

endmodule

// File: tb/tb_spm_driver.sv
// Testbench for spm_driver: two instances (8-bit/latency 1 and 4-bit/latency 3),
// each attached to a behavioural serial-parallel multiplier core.
module tb_spm_driver;
    localparam int unsigned WA = 8;
    localparam int unsigned LA = 1;
    localparam int unsigned WB = 4;
    localparam int unsigned LB = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spm_driver_if #(.WIDTH(WA)) ifa ();
    spm_driver_if #(.WIDTH(WB)) ifb ();

    spm_driver #(.WIDTH(WA), .CORE_LAT(LA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    spm_driver #(.WIDTH(WB), .CORE_LAT(LB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_a[$];
    logic [7:0]  exp_b[$];

    // Behavioural core: accumulates y_k * x << k; product bit k is final once y bit k
    // has been added, and appears on spm_p CORE_LAT cycles after that y bit.
    logic [63:0] acc_a, acc_b, nacc_a, nacc_b;
    logic [5:0]  k_a, k_b;
    logic [7:0]  pipe_a, pipe_b;

    assign nacc_a = acc_a + (ifa.spm_y ? (64'(ifa.spm_x) << k_a) : 64'd0);
    assign nacc_b = acc_b + (ifb.spm_y ? (64'(ifb.spm_x) << k_b) : 64'd0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_a <= '0; k_a <= '0; pipe_a <= '0;
        end else if (ifa.spm_clr) begin
            acc_a <= '0; k_a <= '0; pipe_a <= '0;
        end else begin
            acc_a  <= nacc_a;
            pipe_a <= {pipe_a[6:0], nacc_a[k_a]};
            if (k_a != 6'd63) k_a <= k_a + 6'd1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_b <= '0; k_b <= '0; pipe_b <= '0;
        end else if (ifb.spm_clr) begin
            acc_b <= '0; k_b <= '0; pipe_b <= '0;
        end else begin
            acc_b  <= nacc_b;
            pipe_b <= {pipe_b[6:0], nacc_b[k_b]};
            if (k_b != 6'd63) k_b <= k_b + 6'd1;
        end
    end

    assign ifa.spm_p = pipe_a[LA-1];
    assign ifb.spm_p = pipe_b[LB-1];

    // Called at a falling edge; offers operands once in_ready is seen and returns at
    // the falling edge just after the acceptance edge (the CLEAR cycle).
    task automatic issue_a(input logic [7:0] x, input logic [7:0] y, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ifa.in_ready; t++) @(negedge clk);
        if (ifa.in_ready) begin
            ifa.in_x     = x;
            ifa.in_y     = y;
            ifa.in_valid = 1'b1;
            exp_a.push_back({8'h00, x} * {8'h00, y});
            @(negedge clk);
            ifa.in_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    // Walks falling edges until out_valid, recording clr pulses and the spm_y stream.
    task automatic wait_done_a(output int n, output int clrs, output logic [31:0] yseq,
                               output bit ok);
        n = 0; clrs = 0; yseq = '0; ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (ifa.out_valid) begin
                ok = 1'b1;
                break;
            end
            clrs += int'(ifa.spm_clr);
            if (n < 32) yseq[n] = ifa.spm_y;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_x = '0; ifa.in_y = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_x = '0; ifb.in_y = '0; ifb.out_ready = 1'b0;
        @(negedge clk);
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", ifa.in_ready); end
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", ifa.out_valid); end
        total++; if (ifa.out_p !== 16'h0) begin bad++; $display("FAIL rst_out_p: got %h want 0000", ifa.out_p); end
        total++; if (ifa.spm_x !== 8'h0) begin bad++; $display("FAIL rst_spm_x: got %h want 00", ifa.spm_x); end
        total++; if (ifa.spm_y !== 1'b0 || ifa.spm_clr !== 1'b0) begin bad++; $display("FAIL rst_spm_y_clr: got %b%b want 00", ifa.spm_y, ifa.spm_clr); end
        total++; if (ifb.in_ready !== 1'b1 || ifb.out_valid !== 1'b0) begin bad++; $display("FAIL rst_b_hs: got %b%b want 10", ifb.in_ready, ifb.out_valid); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit ok, okd; int n, clrs; logic [31:0] yseq; logic [15:0] want;
        ifa.out_ready = 1'b1;
        issue_a(8'd3, 8'd5, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_accept: got no acceptance want acceptance"); end
        wait_done_a(n, clrs, yseq, okd);
        total++; if (!okd) begin bad++; $display("FAIL single_timeout: got no out_valid want out_valid"); end
        total++; if (n != 18) begin bad++; $display("FAIL single_latency: got %0d want 18", n); end
        total++; if (clrs != 1) begin bad++; $display("FAIL single_clr: got %0d want 1", clrs); end
        // Bit 0 is the CLEAR cycle; y=5 then follows LSB first.
        total++; if (yseq !== 32'h0000000A) begin bad++; $display("FAIL single_yseq: got %h want 0000000a", yseq); end
        total++; if (ifa.spm_x !== 8'd3) begin bad++; $display("FAIL single_spm_x: got %0d want 3", ifa.spm_x); end
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL single_p: got %h want scoreboard entry", ifa.out_p); end
        else begin
            want = exp_a.pop_front();
            if (ifa.out_p !== want) begin bad++; $display("FAIL single_p: got %h want %h", ifa.out_p, want); end
        end
        @(negedge clk);
        total++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin bad++; $display("FAIL single_idle: got %b%b want 01", ifa.out_valid, ifa.in_ready); end
    endtask

    task automatic test_corners;
        logic [7:0] xs [3];
        logic [7:0] ys [3];
        bit ok, okd; int n, clrs; logic [31:0] yseq; logic [15:0] want;
        xs[0] = 8'd255; ys[0] = 8'd255;
        xs[1] = 8'd0;   ys[1] = 8'd200;
        xs[2] = 8'd200; ys[2] = 8'd1;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_a(xs[i], ys[i], ok);
            wait_done_a(n, clrs, yseq, okd);
            total++; if (!ok || !okd || n != 18) begin bad++; $display("FAIL corner%0d_latency: got %0d want 18", i, n); end
            total++;
            if (exp_a.size() == 0) begin bad++; $display("FAIL corner%0d_p: got %h want scoreboard entry", i, ifa.out_p); end
            else begin
                want = exp_a.pop_front();
                if (ifa.out_p !== want) begin bad++; $display("FAIL corner%0d_p: got %h want %h", i, ifa.out_p, want); end
            end
            @(negedge clk);
            // Next operands must be accepted at the edge right after the handshake.
            total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL corner%0d_b2b_ready: got %b want 1", i, ifa.in_ready); end
        end
    endtask

    task automatic test_backpressure;
        bit ok, okd; int n, clrs; logic [31:0] yseq; logic [15:0] want;
        ifa.out_ready = 1'b0;
        issue_a(8'd9, 8'd13, ok);
        wait_done_a(n, clrs, yseq, okd);
        total++; if (!ok || !okd) begin bad++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", i, ifa.out_valid); end
            total++; if (ifa.out_p !== 16'd117) begin bad++; $display("FAIL bp_p%0d: got %0d want 117", i, ifa.out_p); end
            total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b want 0", i, ifa.in_ready); end
            total++; if (ifa.spm_x !== 8'd9 || ifa.spm_y !== 1'b0 || ifa.spm_clr !== 1'b0) begin bad++; $display("FAIL bp_spm%0d: got x=%0d y=%b clr=%b want x=9 y=0 clr=0", i, ifa.spm_x, ifa.spm_y, ifa.spm_clr); end
        end
        ifa.out_ready = 1'b1;
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL bp_p: got %h want scoreboard entry", ifa.out_p); end
        else begin
            want = exp_a.pop_front();
            if (ifa.out_p !== want) begin bad++; $display("FAIL bp_p: got %h want %h", ifa.out_p, want); end
        end
        @(negedge clk);
        total++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle: got %b%b want 01", ifa.out_valid, ifa.in_ready); end
    endtask

    task automatic test_busy;
        bit ok, okd; int n, clrs, pre_clrs; logic [31:0] yseq; logic [15:0] want;
        ifa.out_ready = 1'b1;
        issue_a(8'd100, 8'd3, ok);
        pre_clrs = 0;
        for (int i = 0; i < 5; i++) begin
            pre_clrs += int'(ifa.spm_clr);
            @(negedge clk);
        end
        total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", ifa.in_ready); end
        ifa.in_x = 8'd7; ifa.in_y = 8'd7; ifa.in_valid = 1'b1;
        pre_clrs += int'(ifa.spm_clr);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        total++; if (ifa.spm_x !== 8'd100) begin bad++; $display("FAIL busy_spm_x: got %0d want 100", ifa.spm_x); end
        wait_done_a(n, clrs, yseq, okd);
        total++; if (!ok || !okd || n + 6 != 18) begin bad++; $display("FAIL busy_latency: got %0d want 18", n + 6); end
        total++; if (pre_clrs + clrs != 1) begin bad++; $display("FAIL busy_clr: got %0d want 1", pre_clrs + clrs); end
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL busy_p: got %h want scoreboard entry", ifa.out_p); end
        else begin
            want = exp_a.pop_front();
            if (ifa.out_p !== want) begin bad++; $display("FAIL busy_p: got %h want %h", ifa.out_p, want); end
        end
        @(negedge clk);
        @(negedge clk);
        total++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.spm_x !== 8'd100) begin bad++; $display("FAIL busy_after: got v=%b r=%b x=%0d want v=0 r=1 x=100", ifa.out_valid, ifa.in_ready, ifa.spm_x); end
    endtask

    task automatic test_reset_mid;
        bit ok, okd; int n, clrs; logic [31:0] yseq; logic [15:0] want;
        ifa.out_ready = 1'b1;
        issue_a(8'hAB, 8'hCD, ok);
        repeat (6) @(negedge clk);   // now in SHIFT with cnt=5
        rst = 1'b1;
        #1;
        total++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_hs: got %b%b want 10", ifa.in_ready, ifa.out_valid); end
        total++; if (ifa.out_p !== 16'h0) begin bad++; $display("FAIL midrst_out_p: got %h want 0000", ifa.out_p); end
        total++; if (ifa.spm_x !== 8'h0 || ifa.spm_y !== 1'b0 || ifa.spm_clr !== 1'b0) begin bad++; $display("FAIL midrst_spm: got x=%h y=%b clr=%b want 00 0 0", ifa.spm_x, ifa.spm_y, ifa.spm_clr); end
        exp_a.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_a(8'd12, 8'd11, ok);
        total++; if (ifa.spm_clr !== 1'b1) begin bad++; $display("FAIL midrst_clear: got %b want 1", ifa.spm_clr); end
        wait_done_a(n, clrs, yseq, okd);
        total++; if (!ok || !okd || n != 18 || clrs != 1) begin bad++; $display("FAIL midrst_seq: got lat=%0d clr=%0d want lat=18 clr=1", n, clrs); end
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL midrst_p: got %h want scoreboard entry", ifa.out_p); end
        else begin
            want = exp_a.pop_front();
            if (ifa.out_p !== want) begin bad++; $display("FAIL midrst_p: got %h want %h", ifa.out_p, want); end
        end
        @(negedge clk);
    endtask

    task automatic test_latency;
        int n, clrs; logic [7:0] want;
        ifb.out_ready = 1'b1;
        total++; if (ifb.in_ready !== 1'b1) begin bad++; $display("FAIL lat_ready: got %b want 1", ifb.in_ready); end
        ifb.in_x = 4'd15; ifb.in_y = 4'd15; ifb.in_valid = 1'b1;
        exp_b.push_back(8'd15 * 8'd15);
        @(negedge clk);
        ifb.in_valid = 1'b0;
        n = 0; clrs = 0;
        while (n < 200 && !ifb.out_valid) begin
            clrs += int'(ifb.spm_clr);
            n++;
            @(negedge clk);
        end
        total++; if (n != 12) begin bad++; $display("FAIL lat_latency: got %0d want 12", n); end
        total++; if (clrs != 1) begin bad++; $display("FAIL lat_clr: got %0d want 1", clrs); end
        total++;
        if (exp_b.size() == 0) begin bad++; $display("FAIL lat_p: got %h want scoreboard entry", ifb.out_p); end
        else begin
            want = exp_b.pop_front();
            if (ifb.out_p !== want) begin bad++; $display("FAIL lat_p: got %0d want %0d", ifb.out_p, want); end
        end
        @(negedge clk);
        total++; if (ifb.out_valid !== 1'b0 || ifb.in_ready !== 1'b1) begin bad++; $display("FAIL lat_idle: got %b%b want 01", ifb.out_valid, ifb.in_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_backpressure();
        test_busy();
        test_reset_mid();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1);
    end

endmodule
